// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core's program-counter stage.
package cpu_pkg;
  localparam int unsigned PC_WIDTH_DEF  = 10;
  localparam int unsigned LUT_IDX_W_DEF = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;
endpackage

// File: rtl/branch_lut.sv
// Branch-target table: one combinational read port, one synchronous write port,
// cleared by reset.
module branch_lut
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
  parameter int unsigned LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] waddr,
  input  logic [PC_WIDTH-1:0]  wdata,
  input  logic [LUT_IDX_W-1:0] raddr,
  output logic [PC_WIDTH-1:0]  rdata
);
  localparam int unsigned Depth = 2 ** LUT_IDX_W;

  logic [PC_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A same-index write is only visible from the next cycle on.
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/pc_unit.sv
// Program-counter sequencer with branch resolution and a start/done handshake.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
  parameter int unsigned LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 branch,
  input  logic                 jump,
  input  logic [7:0]           alu_out,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_WIDTH-1:0]  lut_wdata,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_en,
  output logic                 busy,
  output logic                 done
);
  pc_state_t           state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] lut_rdata;
  logic                done_q;
  logic                redirect;
  logic                unused_alu;

  branch_lut #(
    .PC_WIDTH  (PC_WIDTH),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (lut_idx),
    .rdata (lut_rdata)
  );

  // Only the selected flag in bit 0 matters; upper bits may be X.
  assign unused_alu = ^alu_out[7:1];

  assign redirect = jump | (branch & alu_out[0]);

  always_comb begin
    pc_next = pc_q + PC_WIDTH'(1);
    if (redirect) begin
      pc_next = lut_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
          end
        end
        RUN: begin
          // Halt wins over start and over any redirect in the same cycle.
          if (halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            pc_q <= pc_next;
          end
        end
        DONE: begin
          if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign busy     = (state_q == RUN);
  assign fetch_en = (state_q == RUN) && !stall;
  assign done     = done_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: the driver queues expected outputs per cycle and a
// mid-cycle monitor pops and compares them.
module tb_pc_unit;
  logic       clk = 1'b0;
  logic       reset, start, stall, halt, branch, jump, lut_we;
  logic [7:0] alu_out;
  logic [4:0] lut_idx, lut_waddr;
  logic [9:0] lut_wdata, pc;
  logic       fetch_en, busy, done;

  typedef struct {
    string      name;
    logic [9:0] pc;
    logic       fe;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .halt      (halt),
    .branch    (branch),
    .jump      (jump),
    .alu_out   (alu_out),
    .lut_idx   (lut_idx),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .pc        (pc),
    .fetch_en  (fetch_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Monitor: compares outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({pc, fetch_en, busy, done} !== {e.pc, e.fe, e.busy, e.done}) begin
        errors++;
        $display("FAIL %s: got pc=%h fetch_en=%b busy=%b done=%b, want pc=%h fetch_en=%b busy=%b done=%b",
                 e.name, pc, fetch_en, busy, done, e.pc, e.fe, e.busy, e.done);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch = 1'b0; jump = 1'b0; alu_out = 8'h00; lut_idx = '0;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic expect_out(input string nm, input logic [9:0] epc, input logic efe,
                            input logic eb, input logic ed);
    exp_t e;
    e.name = nm; e.pc = epc; e.fe = efe; e.busy = eb; e.done = ed;
    exp_q.push_back(e);
  endtask

  task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
    lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
  endtask

  task automatic do_jump(input logic [4:0] idx);
    jump = 1'b1; lut_idx = idx;
  endtask

  task automatic do_branch(input logic [7:0] a, input logic [4:0] idx);
    branch = 1'b1; alu_out = a; lut_idx = idx;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0; branch = 1'b0;
    jump = 1'b0; alu_out = 8'h00; lut_idx = '0; lut_we = 1'b0;
    lut_waddr = '0; lut_wdata = '0;

    nxt(); reset = 1'b1;
    nxt(); reset = 1'b1;                      expect_out("reset", 10'h000, 0, 0, 0);
    nxt(); lut_write(5'd3, 10'h120);          expect_out("idle", 10'h000, 0, 0, 0);
    nxt(); lut_write(5'd7, 10'h3FF); start = 1'b1;
    expect_out("idle_start", 10'h000, 0, 0, 0);
    nxt();                                    expect_out("run_pc0", 10'h000, 1, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      nxt();                                  expect_out("count", 10'(i), 1, 1, 0);
    end
    nxt(); do_branch(8'h01, 5'd3);            expect_out("pc4", 10'h004, 1, 1, 0);
    nxt(); do_branch(8'hFE, 5'd3);            expect_out("br_taken", 10'h120, 1, 1, 0);
    nxt(); do_branch(8'bxxxx_xxx1, 5'd3);     expect_out("br_not_taken", 10'h121, 1, 1, 0);
    nxt(); do_branch(8'bxxxx_xxx0, 5'd3);     expect_out("br_x_taken", 10'h120, 1, 1, 0);
    nxt(); do_jump(5'd7); branch = 1'b1;      expect_out("br_x_not_taken", 10'h121, 1, 1, 0);
    nxt();                                    expect_out("jump_max", 10'h3FF, 1, 1, 0);
    nxt();                                    expect_out("wrap", 10'h000, 1, 1, 0);
    nxt();                                    expect_out("pc1", 10'h001, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); stall = 1'b1; do_jump(5'd3); halt = 1'b1; start = 1'b1;
      expect_out("stall", 10'h002, 0, 1, 0);
    end
    nxt(); do_jump(5'd3);                     expect_out("unstall", 10'h002, 1, 1, 0);
    nxt(); lut_write(5'd8, 10'h006); do_jump(5'd8);
    expect_out("jump_after_stall", 10'h120, 1, 1, 0);
    nxt(); do_jump(5'd8);                     expect_out("same_cycle_old", 10'h000, 1, 1, 0);
    nxt(); halt = 1'b1; start = 1'b1;         expect_out("pc6_halt", 10'h006, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      nxt();                                  expect_out("done_hold", 10'h006, 0, 0, 1);
    end
    nxt(); start = 1'b1;                      expect_out("done_start", 10'h006, 0, 0, 1);
    nxt(); start = 1'b1;                      expect_out("restart", 10'h000, 1, 1, 0);
    nxt(); lut_write(5'd10, 10'h042);         expect_out("start_in_run", 10'h001, 1, 1, 0);
    nxt(); do_jump(5'd10);                    expect_out("pc2", 10'h002, 1, 1, 0);
    nxt(); reset = 1'b1; do_jump(5'd3);       expect_out("pc42", 10'h042, 1, 1, 0);
    nxt();                                    expect_out("mid_reset", 10'h000, 0, 0, 0);
    nxt(); start = 1'b1;                      expect_out("idle2", 10'h000, 0, 0, 0);
    nxt(); do_jump(5'd3);                     expect_out("run2", 10'h000, 1, 1, 0);
    nxt(); lut_write(5'd2, 10'h055); do_jump(5'd2);
    expect_out("lut_cleared", 10'h000, 1, 1, 0);
    nxt(); do_jump(5'd2);                     expect_out("wr_rd_old", 10'h000, 1, 1, 0);
    nxt();                                    expect_out("wr_rd_new", 10'h055, 1, 1, 0);
    nxt();                                    expect_out("inc_after", 10'h056, 1, 1, 0);
    nxt();
    nxt();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
